// File: rtl/spi_flash_phy.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_flash_phy
//   Byte-level SPI slave PHY (mode 0, single-bit I/O) for the flash emulator.
//   The SPI pins are oversampled on clk. MOSI is deserialised into bytes for
//   the command decoder, and the decoder's response byte is serialised onto
//   MISO, MSB first.
//
// Parameters
//   FILL_BYTE    byte shifted out when tx_valid=0 at a byte load point
//   SYNC_STAGES  flops per pin synchroniser (legal range 2..4)
//   CNT_WIDTH    width of the per-frame byte counter
//
// Ports
//   clk          system clock, every flop runs on it
//   rstn         asynchronous active-low reset
//   spi_cs_n     chip select from the target (async, active low)
//   spi_clk      SPI clock from the target (async)
//   spi_mosi     serial data in
//   spi_miso     serial data out, idles high
//   spi_miso_oe  high while a frame is active
//   tx_valid     tx_data is valid for the next byte load
//   tx_data      response byte, MSB first
//   rx_data      last complete received byte
//   rx_strobe    one-cycle pulse, rx_data valid in the same cycle
//   frame_active high from synchronised CS fall to synchronised CS rise
//   frame_abort  one-cycle pulse when CS rises with a partial byte
//   byte_cnt     complete bytes in the current frame, saturating
// -----------------------------------------------------------------------------
module spi_flash_phy #(
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2,
    parameter int         CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 spi_cs_n,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic                 tx_valid,
    input  logic [7:0]           tx_data,
    output logic [7:0]           rx_data,
    output logic                 rx_strobe,
    output logic                 frame_active,
    output logic                 frame_abort,
    output logic [CNT_WIDTH-1:0] byte_cnt
);

    typedef enum logic [1:0] {
        ST_ARM    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Pin vector: [2]=cs_n, [1]=sclk, [0]=mosi
    logic [2:0] w_pins;
    logic [2:0] w_sync;
    assign w_pins = {spi_cs_n, spi_clk, spi_mosi};

    // Synchronisers reset to 0 so that a CS held low through reset release
    // never looks like a high level to the ARM state.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_chain;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_chain <= '0;
                end else begin
                    r_chain <= {r_chain[SYNC_STAGES-2:0], w_pins[gi]};
                end
            end
            assign w_sync[gi] = r_chain[SYNC_STAGES-1];
        end
    endgenerate

    logic r_cs_hist;
    logic r_sclk_hist;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cs_hist   <= 1'b0;
            r_sclk_hist <= 1'b0;
        end else begin
            r_cs_hist   <= w_sync[2];
            r_sclk_hist <= w_sync[1];
        end
    end

    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_mosi;

    assign w_cs_fall   =  r_cs_hist   & ~w_sync[2];
    assign w_cs_rise   = ~r_cs_hist   &  w_sync[2];
    assign w_sclk_rise =  w_sync[1]   & ~r_sclk_hist;
    assign w_sclk_fall = ~w_sync[1]   &  r_sclk_hist;
    assign w_mosi      =  w_sync[0];

    // State and datapath registers
    state_t               r_state;
    logic [6:0]           r_rx_shift;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_tx_shift;
    logic                 r_load_pending;
    logic [7:0]           r_rx_data;
    logic                 r_rx_strobe;
    logic                 r_abort;
    logic                 r_active;
    logic [CNT_WIDTH-1:0] r_byte_cnt;

    state_t               w_state_next;
    logic [6:0]           w_rx_shift_next;
    logic [2:0]           w_bit_cnt_next;
    logic [7:0]           w_tx_shift_next;
    logic                 w_load_pending_next;
    logic [7:0]           w_rx_data_next;
    logic                 w_rx_strobe_next;
    logic                 w_abort_next;
    logic                 w_active_next;
    logic [CNT_WIDTH-1:0] w_byte_cnt_next;

    logic [7:0]           w_load_byte;
    logic [7:0]           w_tx_fall_val;
    logic [CNT_WIDTH-1:0] w_byte_cnt_inc;

    assign w_load_byte    = tx_valid ? tx_data : FILL_BYTE;
    // On a falling SCLK the shifter either takes the next response byte
    // (first fall after a completed byte) or advances by one bit.
    assign w_tx_fall_val  = r_load_pending ? w_load_byte : {r_tx_shift[6:0], 1'b0};
    assign w_byte_cnt_inc = (&r_byte_cnt) ? r_byte_cnt : r_byte_cnt + CNT_WIDTH'(1);

    always_comb begin
        w_state_next        = r_state;
        w_rx_shift_next     = r_rx_shift;
        w_bit_cnt_next      = r_bit_cnt;
        w_tx_shift_next     = r_tx_shift;
        w_load_pending_next = r_load_pending;
        w_rx_data_next      = r_rx_data;
        w_rx_strobe_next    = 1'b0;
        w_abort_next        = 1'b0;
        w_active_next       = r_active;
        w_byte_cnt_next     = r_byte_cnt;

        case (r_state)
            ST_ARM: begin
                w_active_next = 1'b0;
                if (w_sync[2]) begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_IDLE: begin
                w_active_next = 1'b0;
                // SCLK edges coinciding with the CS fall are ignored here.
                if (w_cs_fall) begin
                    w_bit_cnt_next      = 3'd0;
                    w_byte_cnt_next     = '0;
                    w_tx_shift_next     = w_load_byte;
                    w_load_pending_next = 1'b0;
                    w_active_next       = 1'b1;
                    w_state_next        = ST_ACTIVE;
                end
            end

            ST_ACTIVE: begin
                // A rising edge is processed before a simultaneous CS rise so
                // the 8th bit still completes its byte.
                if (w_sclk_rise) begin
                    w_rx_shift_next = {r_rx_shift[5:0], w_mosi};
                    w_bit_cnt_next  = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_rx_data_next      = {r_rx_shift, w_mosi};
                        w_rx_strobe_next    = 1'b1;
                        w_byte_cnt_next     = w_byte_cnt_inc;
                        w_load_pending_next = 1'b1;
                    end
                end

                if (w_cs_rise) begin
                    // Bits left over after any completing edge mean a partial byte.
                    w_abort_next        = (w_bit_cnt_next != 3'd0);
                    w_load_pending_next = 1'b0;
                    w_active_next       = 1'b0;
                    w_state_next        = ST_IDLE;
                end else if (w_sclk_fall) begin
                    w_tx_shift_next     = w_tx_fall_val;
                    w_load_pending_next = 1'b0;
                end
            end

            default: begin
                w_state_next  = ST_ARM;
                w_active_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_ARM;
            r_rx_shift     <= '0;
            r_bit_cnt      <= '0;
            r_tx_shift     <= '0;
            r_load_pending <= 1'b0;
            r_rx_data      <= '0;
            r_rx_strobe    <= 1'b0;
            r_abort        <= 1'b0;
            r_active       <= 1'b0;
            r_byte_cnt     <= '0;
        end else begin
            r_state        <= w_state_next;
            r_rx_shift     <= w_rx_shift_next;
            r_bit_cnt      <= w_bit_cnt_next;
            r_tx_shift     <= w_tx_shift_next;
            r_load_pending <= w_load_pending_next;
            r_rx_data      <= w_rx_data_next;
            r_rx_strobe    <= w_rx_strobe_next;
            r_abort        <= w_abort_next;
            r_active       <= w_active_next;
            r_byte_cnt     <= w_byte_cnt_next;
        end
    end

    // MISO follows the shifter MSB during a frame and idles high otherwise.
    assign spi_miso     = r_active ? r_tx_shift[7] : 1'b1;
    assign spi_miso_oe  = r_active;
    assign frame_active = r_active;
    assign rx_data      = r_rx_data;
    assign rx_strobe    = r_rx_strobe;
    assign frame_abort  = r_abort;
    assign byte_cnt     = r_byte_cnt;

endmodule

// File: tb/tb_spi_flash_phy.sv
`timescale 1ns/1ps
module tb_spi_flash_phy;

    localparam int SYNC   = 2;
    localparam int CW     = 4;
    localparam int H      = 2 * SYNC + 3;
    localparam int MAXB   = 20;
    localparam int MAXCNT = (1 << CW) - 1;
    localparam logic [7:0] FILL = 8'hFF;

    typedef struct packed {
        int                    nb;
        logic [MAXB-1:0][7:0]  mosi;
        int                    pbits;
        logic [7:0]            pbyte;
        logic                  fast_end;
        logic                  v0;
        logic [7:0]            d0;
        logic [MAXB-1:0]       rv;
        logic [MAXB-1:0][7:0]  rd;
        logic [MAXB-1:0][7:0]  exp_miso;
        int                    exp_cnt;
        logic                  exp_abort;
        logic [7:0]            exp_last;
    } frame_t;

    logic          clk;
    logic          rstn;
    logic          spi_cs_n;
    logic          spi_clk;
    logic          spi_mosi;
    logic          spi_miso;
    logic          spi_miso_oe;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [7:0]    rx_data;
    logic          rx_strobe;
    logic          frame_active;
    logic          frame_abort;
    logic [CW-1:0] byte_cnt;

    spi_flash_phy #(
        .FILL_BYTE  (FILL),
        .SYNC_STAGES(SYNC),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .frame_active(frame_active),
        .frame_abort (frame_abort),
        .byte_cnt    (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              total;
    int              bad;
    logic [7:0]      rx_q[$];
    int              abort_cnt;
    int              ridx;
    logic [MAXB-1:0]      cur_rv;
    logic [MAXB-1:0][7:0] cur_rd;
    logic [7:0]      prev_rx;
    frame_t          tbl[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks; after each edge record strobes/aborts and act as the
    // response source (present the planned byte the cycle after a strobe).
    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (rx_strobe === 1'b1) begin
                rx_q.push_back(rx_data);
                if (ridx < MAXB) begin
                    tx_valid = cur_rv[ridx];
                    tx_data  = cur_rd[ridx];
                end else begin
                    tx_valid = 1'b0;
                end
                ridx++;
            end
            if (frame_abort === 1'b1) abort_cnt++;
        end
    endtask

    // One SCLK period as a mode-0 master: data set on the low phase, MISO
    // sampled just before the rising edge.
    task automatic bit_phase(input logic m, input logic end_cs, output logic so);
        spi_mosi = m;
        tick(H);
        so = spi_miso;
        spi_clk = 1'b1;
        if (end_cs) spi_cs_n = 1'b1;
        tick(H);
        spi_clk = 1'b0;
    endtask

    // Reference: a frame returns its complete MOSI bytes in order; MISO byte 0
    // is the response presented at CS fall, byte k+1 is the response given
    // after the k-th strobe; the count saturates; a trailing partial aborts.
    function automatic frame_t model(input frame_t f, input logic [7:0] prev);
        frame_t r;
        r = f;
        for (int k = 0; k < f.nb; k++) begin
            if (k == 0) r.exp_miso[k] = f.v0 ? f.d0 : FILL;
            else        r.exp_miso[k] = f.rv[k-1] ? f.rd[k-1] : FILL;
        end
        r.exp_cnt   = (f.nb > MAXCNT) ? MAXCNT : f.nb;
        r.exp_abort = (f.pbits != 0);
        r.exp_last  = (f.nb > 0) ? f.mosi[f.nb-1] : prev;
        return r;
    endfunction

    task automatic run_frame(input frame_t f, input int id);
        logic [7:0] mb;
        logic       sb;
        rx_q.delete();
        abort_cnt = 0;
        ridx      = 0;
        cur_rv    = f.rv;
        cur_rd    = f.rd;
        tx_valid  = f.v0;
        tx_data   = f.d0;
        tick(2);
        spi_cs_n = 1'b0;
        tick(H);
        chk("frame_active_in_frame", 32'(frame_active), 32'd1);
        chk("miso_oe_in_frame", 32'(spi_miso_oe), 32'd1);
        for (int b = 0; b < f.nb; b++) begin
            for (int i = 7; i >= 0; i--) begin
                bit_phase(f.mosi[b][i], (b == f.nb - 1) && (i == 0) && f.fast_end, sb);
                mb[i] = sb;
            end
            chk($sformatf("miso_byte%0d", b), 32'(mb), 32'(f.exp_miso[b]));
        end
        for (int i = 7; i > 7 - f.pbits; i--) begin
            bit_phase(f.pbyte[i], 1'b0, sb);
        end
        if (!f.fast_end) begin
            tick(H);
            spi_cs_n = 1'b1;
        end
        tick(3 * H);
        $display("frame %0d: bytes=%0d partial=%0d strobes=%0d byte_cnt=%0d aborts=%0d rx_data=%02h",
                 id, f.nb, f.pbits, rx_q.size(), byte_cnt, abort_cnt, rx_data);
        chk("strobe_count", 32'(rx_q.size()), 32'(f.nb));
        for (int k = 0; k < f.nb; k++) begin
            if (k < rx_q.size()) chk($sformatf("rx_byte%0d", k), 32'(rx_q[k]), 32'(f.mosi[k]));
        end
        chk("byte_cnt", 32'(byte_cnt), 32'(f.exp_cnt));
        chk("abort_count", 32'(abort_cnt), 32'(f.exp_abort));
        chk("rx_data_held", 32'(rx_data), 32'(f.exp_last));
        chk("frame_active_end", 32'(frame_active), 32'd0);
        chk("miso_oe_end", 32'(spi_miso_oe), 32'd0);
        chk("miso_idle", 32'(spi_miso), 32'd1);
        prev_rx = f.exp_last;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_data"},      32'(rx_data),      32'd0);
        chk({tag, "_rx_strobe"},    32'(rx_strobe),    32'd0);
        chk({tag, "_miso"},         32'(spi_miso),     32'd1);
        chk({tag, "_miso_oe"},      32'(spi_miso_oe),  32'd0);
        chk({tag, "_frame_active"}, 32'(frame_active), 32'd0);
        chk({tag, "_frame_abort"},  32'(frame_abort),  32'd0);
        chk({tag, "_byte_cnt"},     32'(byte_cnt),     32'd0);
    endtask

    initial begin
        frame_t f;
        logic   sb;
        total = 0; bad = 0; abort_cnt = 0; ridx = 0; prev_rx = 8'h00;
        cur_rv = '0; cur_rd = '0;
        rstn = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;

        // Table of directed frames with hand-computed expectations.
        for (int i = 0; i < 4; i++) tbl[i] = '0;
        // Read-ID style: response 0xC2 given after the first strobe.
        tbl[0].nb = 2; tbl[0].mosi[0] = 8'h9F; tbl[0].mosi[1] = 8'h00;
        tbl[0].rv[0] = 1'b1; tbl[0].rd[0] = 8'hC2;
        tbl[0].exp_miso[0] = 8'hFF; tbl[0].exp_miso[1] = 8'hC2;
        tbl[0].exp_cnt = 2; tbl[0].exp_abort = 1'b0; tbl[0].exp_last = 8'h00;
        // Read command plus address then 4 dummy bytes, no response at all.
        tbl[1].nb = 7;
        tbl[1].mosi[0] = 8'h03; tbl[1].mosi[1] = 8'h30; tbl[1].mosi[2] = 8'h42;
        for (int k = 3; k < 7; k++) tbl[1].mosi[k] = 8'h5A;
        for (int k = 0; k < 7; k++) tbl[1].exp_miso[k] = 8'hFF;
        tbl[1].exp_cnt = 7; tbl[1].exp_abort = 1'b0; tbl[1].exp_last = 8'h5A;
        // CS rises after 5 bits of 0xA5: abort, rx_data keeps 0x5A.
        tbl[2].nb = 0; tbl[2].pbits = 5; tbl[2].pbyte = 8'hA5;
        tbl[2].v0 = 1'b1; tbl[2].d0 = 8'h3C;
        tbl[2].exp_cnt = 0; tbl[2].exp_abort = 1'b1; tbl[2].exp_last = 8'h5A;
        // CS rises on the same clock as the 8th SCLK rise: byte completes.
        tbl[3].nb = 1; tbl[3].mosi[0] = 8'hC3; tbl[3].fast_end = 1'b1;
        tbl[3].v0 = 1'b1; tbl[3].d0 = 8'h81;
        tbl[3].exp_miso[0] = 8'h81;
        tbl[3].exp_cnt = 1; tbl[3].exp_abort = 1'b0; tbl[3].exp_last = 8'hC3;

        tick(2);
        check_reset_values("reset");
        rstn = 1'b1;
        tick(SYNC + 4);

        for (int i = 0; i < 4; i++) run_frame(tbl[i], i);

        // SCLK toggling with CS high changes nothing.
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            spi_clk = 1'b1; tick(H);
            spi_clk = 1'b0; tick(H);
        end
        $display("idle sclk: strobes=%0d byte_cnt=%0d", rx_q.size(), byte_cnt);
        chk("idle_sclk_strobes", 32'(rx_q.size()), 32'd0);
        chk("idle_sclk_byte_cnt", 32'(byte_cnt), 32'(tbl[3].exp_cnt));
        chk("idle_sclk_active", 32'(frame_active), 32'd0);

        // Reset mid-byte with CS held low; the held-low CS must be ignored.
        spi_cs_n = 1'b0;
        tick(H);
        for (int i = 0; i < 3; i++) bit_phase(1'b1, 1'b0, sb);
        rstn = 1'b0;
        #1;
        check_reset_values("midreset");
        tick(2);
        rstn = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 8; i++) bit_phase(i[0], 1'b0, sb);
        $display("post-reset cs low: strobes=%0d frame_active=%0d", rx_q.size(), frame_active);
        chk("armed_no_strobe", 32'(rx_q.size()), 32'd0);
        chk("armed_inactive", 32'(frame_active), 32'd0);
        chk("armed_miso", 32'(spi_miso), 32'd1);
        spi_cs_n = 1'b1;
        tick(2 * H);
        prev_rx = 8'h00;
        f = '0;
        f.nb = 1; f.mosi[0] = 8'h05;
        f = model(f, prev_rx);
        run_frame(f, 100);

        // Randomised frames; the first is long enough to saturate byte_cnt
        // with a fresh response byte after every strobe.
        for (int it = 0; it < 10; it++) begin
            f = '0;
            f.nb = (it == 0) ? 17 : $urandom_range(0, 6);
            for (int b = 0; b < f.nb; b++) begin
                f.mosi[b] = 8'($urandom);
                f.rd[b]   = 8'($urandom);
                f.rv[b]   = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            f.v0    = 1'($urandom_range(0, 1));
            f.d0    = 8'($urandom);
            f.pbits = (it != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            f.pbyte = 8'($urandom);
            f.fast_end = (f.nb > 0 && f.pbits == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            f = model(f, prev_rx);
            run_frame(f, 200 + it);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
